// File: rtl/conv_layer_sequencer_if.sv
// conv_layer_sequencer_if: FIFO, convolution and pooling handshakes between the sequencer (master) and its datapath (slave)
interface conv_layer_sequencer_if #(
  parameter int BITS_PER_COORDINATE = 8,
  parameter int IN_CHANNELS = 2
);
  localparam int W = 2 * BITS_PER_COORDINATE + IN_CHANNELS + 1;
  logic fifo_empty;
  logic fifo_read_enable;
  logic [W-1:0] fifo_read_data;
  logic conv_start;
  logic [BITS_PER_COORDINATE-1:0] conv_x;
  logic [BITS_PER_COORDINATE-1:0] conv_y;
  logic [IN_CHANNELS-1:0] conv_spikes;
  logic conv_done;
  logic pool_start;
  logic pool_done;
  logic pool_hold;
  logic output_fifo_full_next;
  logic [1:0] arbiter_mode;
  modport master (
    input fifo_empty, fifo_read_data, conv_done, pool_done, output_fifo_full_next,
    output fifo_read_enable, conv_start, conv_x, conv_y, conv_spikes, pool_start, pool_hold, arbiter_mode
  );
  modport slave (
    output fifo_empty, fifo_read_data, conv_done, pool_done, output_fifo_full_next,
    input fifo_read_enable, conv_start, conv_x, conv_y, conv_spikes, pool_start, pool_hold, arbiter_mode
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: event-driven conv/pool scheduler for one layer; optional statistics counters enabled by CONV_SEQ_STATS_EN
module conv_layer_sequencer #(
  parameter int BITS_PER_COORDINATE = 8,
  parameter int IN_CHANNELS = 2,
  parameter int IMG_WIDTH = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int MAX_EVENTS_PER_TIMESTEP = 1024,
  parameter int STATS_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  conv_layer_sequencer_if.master bus,
  output logic busy,
  output logic overflow_flag,
  output logic [STATS_WIDTH-1:0] stat_events,
  output logic [STATS_WIDTH-1:0] stat_timesteps,
  output logic [STATS_WIDTH-1:0] stat_dropped
);
  localparam int BPC = BITS_PER_COORDINATE;
  localparam int W = 2 * BPC + IN_CHANNELS + 1;
  localparam int CW = $clog2(MAX_EVENTS_PER_TIMESTEP + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_EVENTS_PER_TIMESTEP);
  typedef enum logic [2:0] {IDLE, FETCH, CONV, POOL, PAUSE} state_t;
  state_t state, state_d;
  logic [CW-1:0] ev_cnt, cnt_d;
  logic [BPC-1:0] x_d, y_d;
  logic [IN_CHANNELS-1:0] sp_d;
  logic rd_d, cs_d, ps_d, ovf_d;
  logic w_ts, w_bad, word_valid;
  logic [BPC-1:0] w_x, w_y;
  logic [IN_CHANNELS-1:0] w_sp;
  assign w_ts = bus.fifo_read_data[W-1];
  assign w_x = bus.fifo_read_data[W-2 -: BPC];
  assign w_y = bus.fifo_read_data[BPC+IN_CHANNELS-1 -: BPC];
  assign w_sp = bus.fifo_read_data[IN_CHANNELS-1:0];
  assign w_bad = int'(w_x) >= IMG_WIDTH || int'(w_y) >= IMG_HEIGHT || w_sp == '0;
  assign word_valid = state == FETCH && !bus.fifo_read_enable;
  always_comb begin
    state_d = state;
    rd_d = 1'b0;
    cs_d = 1'b0;
    ps_d = 1'b0;
    ovf_d = overflow_flag;
    cnt_d = ev_cnt;
    x_d = bus.conv_x;
    y_d = bus.conv_y;
    sp_d = bus.conv_spikes;
    case (state)
      IDLE: begin
        if (!enable) state_d = PAUSE;
        else if (ev_cnt == MAXC) begin
          state_d = POOL;
          ps_d = 1'b1;
          ovf_d = 1'b1;
        end else if (!bus.fifo_empty) begin
          state_d = FETCH;
          rd_d = 1'b1;
        end
      end
      FETCH: begin
        if (word_valid) begin
          if (w_ts) begin
            state_d = POOL;
            ps_d = 1'b1;
          end else if (w_bad) state_d = IDLE;
          else begin
            state_d = CONV;
            cs_d = 1'b1;
            cnt_d = ev_cnt + 1'b1;
            x_d = w_x;
            y_d = w_y;
            sp_d = w_sp;
          end
        end
      end
      CONV: begin
        if (bus.conv_done) begin
          state_d = enable && !bus.fifo_empty && ev_cnt < MAXC ? FETCH : IDLE;
          rd_d = enable && !bus.fifo_empty && ev_cnt < MAXC;
        end
      end
      POOL: begin
        if (bus.pool_done) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      PAUSE: state_d = enable ? IDLE : PAUSE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ev_cnt <= '0;
      bus.fifo_read_enable <= 1'b0;
      bus.conv_start <= 1'b0;
      bus.pool_start <= 1'b0;
      bus.conv_x <= '0;
      bus.conv_y <= '0;
      bus.conv_spikes <= '0;
      bus.pool_hold <= 1'b0;
      bus.arbiter_mode <= 2'd0;
      busy <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      state <= state_d;
      ev_cnt <= cnt_d;
      bus.fifo_read_enable <= rd_d;
      bus.conv_start <= cs_d;
      bus.pool_start <= ps_d;
      bus.conv_x <= x_d;
      bus.conv_y <= y_d;
      bus.conv_spikes <= sp_d;
      bus.pool_hold <= state_d == POOL && bus.output_fifo_full_next;
      bus.arbiter_mode <= {1'b0, state_d == POOL};
      busy <= state_d != IDLE && state_d != PAUSE;
      overflow_flag <= ovf_d;
    end
  end
`ifdef CONV_SEQ_STATS_EN
  logic acc, drop, pdone;
  assign acc = word_valid && !w_ts && !w_bad;
  assign drop = word_valid && !w_ts && w_bad;
  assign pdone = state == POOL && bus.pool_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_events <= '0;
      stat_timesteps <= '0;
      stat_dropped <= '0;
    end else begin
      if (acc && ~&stat_events) stat_events <= stat_events + 1'b1;
      if (pdone && ~&stat_timesteps) stat_timesteps <= stat_timesteps + 1'b1;
      if (drop && ~&stat_dropped) stat_dropped <= stat_dropped + 1'b1;
    end
  end
`else
  assign stat_events = '0;
  assign stat_timesteps = '0;
  assign stat_dropped = '0;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: directed scenarios for the conv-layer sequencer with FIFO, convolution and pooling responders
module tb_conv_layer_sequencer;
`ifdef CONV_SEQ_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic busy, overflow_flag;
  logic [31:0] stat_events, stat_timesteps, stat_dropped;
  int total = 0;
  int bad = 0;
  int n_cs = 0;
  int n_ps = 0;
  int rp = 0;
  int wp = 0;
  logic [18:0] mem [0:63];
  logic [2:0] sh = 3'b000;
  logic pact = 1'b0;
  int pc = 0;
  conv_layer_sequencer_if #(.BITS_PER_COORDINATE(8), .IN_CHANNELS(2)) bus();
  conv_layer_sequencer #(.MAX_EVENTS_PER_TIMESTEP(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus), .busy(busy), .overflow_flag(overflow_flag),
    .stat_events(stat_events), .stat_timesteps(stat_timesteps), .stat_dropped(stat_dropped)
  );
  always #5 clk = ~clk;
  assign bus.fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (bus.fifo_read_enable === 1'b1) begin
      bus.fifo_read_data <= mem[rp];
      rp <= rp + 1;
    end
    if (bus.conv_start === 1'b1) n_cs <= n_cs + 1;
    if (bus.pool_start === 1'b1) n_ps <= n_ps + 1;
    sh <= {sh[1:0], bus.conv_start === 1'b1};
    bus.conv_done <= sh[2];
    bus.pool_done <= 1'b0;
    if (bus.pool_start === 1'b1) begin
      pact <= 1'b1;
      pc <= 0;
    end else if (pact && bus.pool_hold !== 1'b1) begin
      if (pc == 2) begin
        bus.pool_done <= 1'b1;
        pact <= 1'b0;
      end else pc <= pc + 1;
    end
  end
  function automatic logic [18:0] ev(input bit ts, input int x, input int y, input int sp);
    return {ts, x[7:0], y[7:0], sp[1:0]};
  endfunction
  task automatic push(input logic [18:0] w);
    mem[wp] = w;
    wp = wp + 1;
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    bus.output_fifo_full_next = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic drain(output bit ok);
    int q;
    q = 0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      q = (!busy && bus.fifo_empty && !bus.fifo_read_enable && !bus.pool_start) ? q + 1 : 0;
      ok = q >= 3;
    end
  endtask
  task automatic test_reset;
    int p0;
    bit ok;
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    bus.output_fifo_full_next = 1'b0;
    push(ev(0, 1, 1, 3));
    p0 = rp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.fifo_read_enable !== 1'b0) begin
        bad++;
        $display("FAIL reset_pop cycle %0d: got %b want 0", i, bus.fifo_read_enable);
      end
    end
    total++;
    if ({bus.conv_start, bus.pool_start, bus.conv_x, bus.conv_y, bus.conv_spikes, bus.pool_hold, busy, overflow_flag} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {bus.conv_start, bus.pool_start, bus.conv_x, bus.conv_y, bus.conv_spikes, bus.pool_hold, busy, overflow_flag});
    end
    total++;
    if (bus.arbiter_mode !== 2'd0) begin
      bad++;
      $display("FAIL reset_arbiter: got %0d want 0", bus.arbiter_mode);
    end
    total++;
    if ({stat_events, stat_timesteps, stat_dropped} !== 96'd0) begin
      bad++;
      $display("FAIL reset_stats: got %0d/%0d/%0d want 0", stat_events, stat_timesteps, stat_dropped);
    end
    total++;
    if (rp != p0) begin
      bad++;
      $display("FAIL reset_no_pop: got %0d pops want 0", rp - p0);
    end
    reset = 1'b0;
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reset_drain: got timeout want idle");
    end
  endtask
  task automatic test_single;
    int c0;
    @(negedge clk);
    do_reset;
    c0 = n_cs;
    push(ev(0, 3, 5, 1));
    for (int i = 0; i < 30 && bus.conv_start !== 1'b1; i++) @(negedge clk);
    total++;
    if (bus.conv_start !== 1'b1) begin
      bad++;
      $display("FAIL single_start: got %b want 1", bus.conv_start);
    end
    total++;
    if ({bus.conv_x, bus.conv_y, bus.conv_spikes} !== {8'd3, 8'd5, 2'b01}) begin
      bad++;
      $display("FAIL single_event: got x=%0d y=%0d s=%b want x=3 y=5 s=01", bus.conv_x, bus.conv_y, bus.conv_spikes);
    end
    @(negedge clk);
    total++;
    if (bus.conv_start !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse: got %b want 0", bus.conv_start);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({bus.conv_done, busy, bus.conv_x, bus.conv_y} !== {1'b1, 1'b1, 8'd3, 8'd5}) begin
      bad++;
      $display("FAIL single_hold: got done=%b busy=%b x=%0d y=%0d want 1 1 3 5", bus.conv_done, busy, bus.conv_x, bus.conv_y);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || n_cs - c0 != 1) begin
      bad++;
      $display("FAIL single_idle: got busy=%b starts=%0d want busy=0 starts=1", busy, n_cs - c0);
    end
  endtask
  task automatic test_drop;
    int c0;
    bit ok;
    do_reset;
    c0 = n_cs;
    push(ev(0, 32, 5, 1));
    push(ev(0, 4, 6, 2));
    for (int i = 0; i < 40 && bus.conv_start !== 1'b1; i++) @(negedge clk);
    total++;
    if ({bus.conv_start, bus.conv_x, bus.conv_y, bus.conv_spikes} !== {1'b1, 8'd4, 8'd6, 2'b10}) begin
      bad++;
      $display("FAIL drop_first: got start=%b x=%0d y=%0d s=%b want 1 4 6 10", bus.conv_start, bus.conv_x, bus.conv_y, bus.conv_spikes);
    end
    drain(ok);
    total++;
    if (!ok || n_cs - c0 != 1) begin
      bad++;
      $display("FAIL drop_starts: got %0d (drained=%b) want 1", n_cs - c0, ok);
    end
    total++;
    if (stat_dropped !== 32'(STATS) || stat_events !== 32'(STATS)) begin
      bad++;
      $display("FAIL drop_stats: got dropped=%0d events=%0d want %0d %0d", stat_dropped, stat_events, STATS, STATS);
    end
    push(ev(0, 1, 32, 1));
    push(ev(0, 2, 2, 0));
    push(ev(0, 31, 31, 3));
    for (int i = 0; i < 60 && bus.conv_start !== 1'b1; i++) @(negedge clk);
    total++;
    if ({bus.conv_start, bus.conv_x, bus.conv_y, bus.conv_spikes} !== {1'b1, 8'd31, 8'd31, 2'b11}) begin
      bad++;
      $display("FAIL drop_edge: got start=%b x=%0d y=%0d s=%b want 1 31 31 11", bus.conv_start, bus.conv_x, bus.conv_y, bus.conv_spikes);
    end
    drain(ok);
    total++;
    if (!ok || n_cs - c0 != 2 || stat_dropped !== 32'(3 * STATS)) begin
      bad++;
      $display("FAIL drop_total: got starts=%0d dropped=%0d want 2 %0d", n_cs - c0, stat_dropped, 3 * STATS);
    end
  endtask
  task automatic test_pool;
    int c0, p0, arb_bad;
    do_reset;
    c0 = n_cs;
    p0 = n_ps;
    arb_bad = 0;
    push(ev(0, 7, 1, 1));
    push(ev(0, 8, 1, 1));
    push(ev(0, 9, 1, 1));
    push(ev(1, 0, 0, 0));
    for (int i = 0; i < 100 && bus.pool_start !== 1'b1; i++) @(negedge clk);
    total++;
    if ({bus.pool_start, bus.arbiter_mode, overflow_flag} !== {1'b1, 2'd1, 1'b0} || n_cs - c0 != 3) begin
      bad++;
      $display("FAIL pool_start: got ps=%b arb=%0d ovf=%b convs=%0d want 1 1 0 3", bus.pool_start, bus.arbiter_mode, overflow_flag, n_cs - c0);
    end
    bus.output_fifo_full_next = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus.pool_hold, bus.arbiter_mode, bus.pool_done} !== {1'b1, 2'd1, 1'b0}) begin
        bad++;
        $display("FAIL pool_hold cycle %0d: got hold=%b arb=%0d done=%b want 1 1 0", i, bus.pool_hold, bus.arbiter_mode, bus.pool_done);
      end
    end
    bus.output_fifo_full_next = 1'b0;
    for (int i = 0; i < 20 && bus.pool_done !== 1'b1; i++) begin
      @(negedge clk);
      if (bus.arbiter_mode !== 2'd1) arb_bad++;
    end
    total++;
    if (bus.pool_done !== 1'b1 || arb_bad != 0 || bus.pool_hold !== 1'b0) begin
      bad++;
      $display("FAIL pool_run: got done=%b arb_low=%0d hold=%b want 1 0 0", bus.pool_done, arb_bad, bus.pool_hold);
    end
    @(negedge clk);
    total++;
    if ({bus.arbiter_mode, busy} !== {2'd0, 1'b0} || n_ps - p0 != 1 || stat_timesteps !== 32'(STATS)) begin
      bad++;
      $display("FAIL pool_end: got arb=%0d busy=%b pools=%0d ts=%0d want 0 0 1 %0d", bus.arbiter_mode, busy, n_ps - p0, stat_timesteps, STATS);
    end
  endtask
  task automatic test_overflow;
    int c0, p0, r0;
    bit ok;
    do_reset;
    c0 = n_cs;
    p0 = n_ps;
    r0 = rp;
    for (int i = 1; i <= 6; i++) push(ev(0, i, 2, 1));
    for (int i = 0; i < 200 && bus.pool_start !== 1'b1; i++) @(negedge clk);
    total++;
    if ({bus.pool_start, overflow_flag, bus.arbiter_mode} !== {1'b1, 1'b1, 2'd1} || n_cs - c0 != 4 || rp - r0 != 4) begin
      bad++;
      $display("FAIL ovf_force: got ps=%b ovf=%b arb=%0d convs=%0d pops=%0d want 1 1 1 4 4", bus.pool_start, overflow_flag, bus.arbiter_mode, n_cs - c0, rp - r0);
    end
    for (int i = 0; i < 30 && bus.pool_done !== 1'b1; i++) @(negedge clk);
    total++;
    if (bus.pool_done !== 1'b1 || n_cs - c0 != 4) begin
      bad++;
      $display("FAIL ovf_pool_done: got done=%b convs=%0d want 1 4", bus.pool_done, n_cs - c0);
    end
    drain(ok);
    total++;
    if (!ok || n_cs - c0 != 6 || bus.conv_x !== 8'd6 || overflow_flag !== 1'b1 || n_ps - p0 != 1) begin
      bad++;
      $display("FAIL ovf_rest: got convs=%0d x=%0d ovf=%b pools=%0d want 6 6 1 1", n_cs - c0, bus.conv_x, overflow_flag, n_ps - p0);
    end
    total++;
    if (stat_events !== 32'(6 * STATS) || stat_timesteps !== 32'(STATS)) begin
      bad++;
      $display("FAIL ovf_stats: got events=%0d ts=%0d want %0d %0d", stat_events, stat_timesteps, 6 * STATS, STATS);
    end
  endtask
  task automatic test_pause;
    int c0, r0;
    bit ok;
    do_reset;
    c0 = n_cs;
    push(ev(0, 10, 11, 1));
    push(ev(0, 12, 13, 2));
    for (int i = 0; i < 30 && bus.conv_start !== 1'b1; i++) @(negedge clk);
    enable = 1'b0;
    total++;
    if ({bus.conv_start, bus.conv_x} !== {1'b1, 8'd10}) begin
      bad++;
      $display("FAIL pause_first: got start=%b x=%0d want 1 10", bus.conv_start, bus.conv_x);
    end
    for (int i = 0; i < 20 && bus.conv_done !== 1'b1; i++) @(negedge clk);
    r0 = rp;
    repeat (6) @(negedge clk);
    total++;
    if (rp != r0 || busy !== 1'b0 || n_cs - c0 != 1) begin
      bad++;
      $display("FAIL pause_hold: got pops=%0d busy=%b convs=%0d want 0 0 1", rp - r0, busy, n_cs - c0);
    end
    enable = 1'b1;
    for (int i = 0; i < 30 && bus.conv_start !== 1'b1; i++) @(negedge clk);
    total++;
    if ({bus.conv_start, bus.conv_x, bus.conv_y} !== {1'b1, 8'd12, 8'd13}) begin
      bad++;
      $display("FAIL pause_resume: got start=%b x=%0d y=%0d want 1 12 13", bus.conv_start, bus.conv_x, bus.conv_y);
    end
    drain(ok);
    total++;
    if (!ok || n_cs - c0 != 2) begin
      bad++;
      $display("FAIL pause_drain: got convs=%0d drained=%b want 2 1", n_cs - c0, ok);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.output_fifo_full_next = 1'b0;
    test_reset;
    test_single;
    test_drop;
    test_pool;
    test_overflow;
    test_pause;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
